// File: rtl/lsu_arb.sv
// lsu_arb: two-master arbiter in front of the lsu data port, one lsu access cycle per grant.
// Define LSU_ARB_RR_EN for round-robin tie breaking; otherwise m0 has fixed priority.
module lsu_arb #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_wren,
    input  logic [2:0]        m0_rwsel,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_wren,
    input  logic [2:0]        m1_rwsel,
    output logic              m0_ack,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m_rdata,
    output logic [ADDR_W-1:0] lsu_addr,
    output logic [DATA_W-1:0] lsu_wdata,
    output logic              lsu_wren,
    output logic [2:0]        lsu_rwsel,
    input  logic [DATA_W-1:0] lsu_rdata,
    output logic [1:0]        gnt
);
    localparam logic [2:0] IDLE = 3'b001;
    localparam logic [2:0] ACC  = 3'b010;
    localparam logic [2:0] RESP = 3'b100;

    logic [2:0] state;
    logic [1:0] owner, cand, win;
    logic       acc;

    assign acc  = state[1];
    // the owner's req is stale during RESP, so it cannot re-win there
    assign cand = state[2] ? ({m1_req, m0_req} & ~owner) : state[0] ? {m1_req, m0_req} : 2'b00;

`ifdef LSU_ARB_RR_EN
    logic ptr;
    assign win = (&cand) ? (ptr ? 2'b01 : 2'b10) : cand;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= 1'b1;
        else if (|win)
            ptr <= win[1];
    end
`else
    assign win = cand[0] ? 2'b01 : cand;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            owner   <= 2'b00;
            m_rdata <= '0;
        end else begin
            state <= (|win) ? ACC : acc ? RESP : IDLE;
            owner <= (|win) ? win : acc ? owner : 2'b00;
            if (acc)
                m_rdata <= lsu_rdata;
        end
    end

    assign gnt       = owner;
    assign m0_ack    = state[2] & owner[0];
    assign m1_ack    = state[2] & owner[1];
    assign lsu_addr  = acc ? (owner[1] ? m1_addr : m0_addr) : '0;
    assign lsu_wdata = acc ? (owner[1] ? m1_wdata : m0_wdata) : '0;
    assign lsu_wren  = acc & (owner[1] ? m1_wren : m0_wren);
    assign lsu_rwsel = acc ? (owner[1] ? m1_rwsel : m0_rwsel) : 3'b000;
endmodule

// File: tb/tb_lsu_arb.sv
// tb_lsu_arb: directed cycle checks plus per-master ack/read-data scoreboard for lsu_arb.
module tb_lsu_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [11:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_wren = 1'b0, m1_wren = 1'b0;
    logic [2:0]  m0_rwsel = '0, m1_rwsel = '0;
    logic        m0_ack, m1_ack;
    logic [31:0] m_rdata;
    logic [11:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_wren;
    logic [2:0]  lsu_rwsel;
    logic [31:0] lsu_rdata;
    logic [1:0]  gnt;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    logic p0 = 1'b0, p1 = 1'b0;

    lsu_arb dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wren(m0_wren), .m0_rwsel(m0_rwsel),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wren(m1_wren), .m1_rwsel(m1_rwsel),
        .m0_ack(m0_ack), .m1_ack(m1_ack), .m_rdata(m_rdata),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wren(lsu_wren), .lsu_rwsel(lsu_rwsel),
        .lsu_rdata(lsu_rdata), .gnt(gnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [11:0] a);
        return 32'hDEADBEEF ^ {20'd0, a ^ 12'h010};
    endfunction

    assign lsu_rdata = rd(lsu_addr);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic st(input string tag, input logic [1:0] g, input logic a0, input logic a1,
                      input logic w, input logic [11:0] a);
        chk({tag, " gnt"}, {30'd0, gnt}, {30'd0, g});
        chk({tag, " acks"}, {30'd0, m1_ack, m0_ack}, {30'd0, a1, a0});
        chk({tag, " wren"}, {31'd0, lsu_wren}, {31'd0, w});
        chk({tag, " addr"}, {20'd0, lsu_addr}, {20'd0, a});
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("one ack", {31'd0, m0_ack & m1_ack}, 32'd0);
            chk("no repeat ack", {30'd0, m1_ack & p1, m0_ack & p0}, 32'd0);
            if (m0_ack) begin
                if (exp0.size() == 0) chk("m0 unexpected ack", 32'd1, 32'd0);
                else chk("m0 rdata", m_rdata, exp0.pop_front());
            end
            if (m1_ack) begin
                if (exp1.size() == 0) chk("m1 unexpected ack", 32'd1, 32'd0);
                else chk("m1 rdata", m_rdata, exp1.pop_front());
            end
        end
        p0 = m0_ack;
        p1 = m1_ack;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic first;
        logic w;
        logic [11:0] a;
        repeat (2) cyc();
        st("reset", 2'b00, 1'b0, 1'b0, 1'b0, 12'h000);
        chk("reset m_rdata", m_rdata, 32'd0);
        chk("reset wdata", lsu_wdata, 32'd0);
        rst = 1'b1;
        cyc();

        // m0 load
        m0_addr = 12'h010; m0_rwsel = 3'd2; m0_req = 1'b1;
        exp0.push_back(32'hDEADBEEF);
        cyc(); st("m0 load acc", 2'b01, 1'b0, 1'b0, 1'b0, 12'h010);
        cyc(); st("m0 load resp", 2'b01, 1'b1, 1'b0, 1'b0, 12'h000);
        chk("m0 load m_rdata", m_rdata, 32'hDEADBEEF);
        m0_req = 1'b0;
        cyc(); st("m0 load idle", 2'b00, 1'b0, 1'b0, 1'b0, 12'h000);

        // m1 store
        m1_addr = 12'h7F0; m1_wdata = 32'h12345678; m1_wren = 1'b1; m1_rwsel = 3'd2; m1_req = 1'b1;
        exp1.push_back(rd(12'h7F0));
        cyc(); st("m1 store acc", 2'b10, 1'b0, 1'b0, 1'b1, 12'h7F0);
        chk("m1 store wdata", lsu_wdata, 32'h12345678);
        chk("m1 store rwsel", {29'd0, lsu_rwsel}, 32'd2);
        cyc(); st("m1 store resp", 2'b10, 1'b0, 1'b1, 1'b0, 12'h000);
        chk("resp wdata zero", lsu_wdata, 32'd0);
        m1_req = 1'b0; m1_wren = 1'b0;
        cyc(); st("m1 store idle", 2'b00, 1'b0, 1'b0, 1'b0, 12'h000);

        // simultaneous: m0 first, m1 straight from RESP
        m0_addr = 12'h020; m1_addr = 12'h030; m0_req = 1'b1; m1_req = 1'b1;
        exp0.push_back(rd(12'h020)); exp1.push_back(rd(12'h030));
        cyc(); st("tie acc0", 2'b01, 1'b0, 1'b0, 1'b0, 12'h020);
        cyc(); st("tie resp0", 2'b01, 1'b1, 1'b0, 1'b0, 12'h000);
        m0_req = 1'b0;
        cyc(); st("tie acc1", 2'b10, 1'b0, 1'b0, 1'b0, 12'h030);
        cyc(); st("tie resp1", 2'b10, 1'b0, 1'b1, 1'b0, 12'h000);
        m1_req = 1'b0;
        cyc(); st("tie idle", 2'b00, 1'b0, 1'b0, 1'b0, 12'h000);

        // m0 back-to-back: one access every 3 cycles
        for (int i = 0; i < 3; i++) begin
            a = 12'h100 + 12'(i * 4);
            m0_addr = a; m0_req = 1'b1;
            exp0.push_back(rd(a));
            cyc(); st("b2b acc", 2'b01, 1'b0, 1'b0, 1'b0, a);
            cyc(); st("b2b resp", 2'b01, 1'b1, 1'b0, 1'b0, 12'h000);
            if (i == 2) m0_req = 1'b0;
            cyc(); st("b2b gap", 2'b00, 1'b0, 1'b0, 1'b0, 12'h000);
        end

        // both masters requesting continuously: grants alternate
`ifdef LSU_ARB_RR_EN
        first = 1'b1;
`else
        first = 1'b0;
`endif
        m0_addr = 12'h200; m1_addr = 12'h240; m0_req = 1'b1; m1_req = 1'b1;
        exp0.push_back(rd(12'h200)); exp1.push_back(rd(12'h240));
        for (int j = 0; j < 4; j++) begin
            w = first ^ j[0];
            a = w ? m1_addr : m0_addr;
            cyc(); st("alt acc", w ? 2'b10 : 2'b01, 1'b0, 1'b0, 1'b0, a);
            cyc(); st("alt resp", w ? 2'b10 : 2'b01, ~w, w, 1'b0, 12'h000);
            a = a + 12'd4;
            if (j >= 2) begin
                if (w) m1_req = 1'b0; else m0_req = 1'b0;
            end else if (w) begin
                m1_addr = a; exp1.push_back(rd(a));
            end else begin
                m0_addr = a; exp0.push_back(rd(a));
            end
        end
        cyc(); st("alt idle", 2'b00, 1'b0, 1'b0, 1'b0, 12'h000);

        // reset in the middle of an m1 store access
        m1_addr = 12'h3C0; m1_wdata = 32'hCAFEF00D; m1_wren = 1'b1; m1_req = 1'b1;
        cyc(); st("rst acc", 2'b10, 1'b0, 1'b0, 1'b1, 12'h3C0);
        #2 rst = 1'b0;
        #1 st("rst abort", 2'b00, 1'b0, 1'b0, 1'b0, 12'h000);
        chk("rst m_rdata", m_rdata, 32'd0);
        m1_req = 1'b0; m1_wren = 1'b0;
        cyc(); st("rst hold", 2'b00, 1'b0, 1'b0, 1'b0, 12'h000);
        rst = 1'b1;
        repeat (3) begin
            cyc(); st("after rst", 2'b00, 1'b0, 1'b0, 1'b0, 12'h000);
        end
        chk("m0 scoreboard empty", exp0.size(), 32'd0);
        chk("m1 scoreboard empty", exp1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
